// File: rtl/gmii_rx_frame_check.sv
// GMII receive front end: strips preamble/SFD, forwards frame bytes with SOF/EOF,
// checks FCS and length, and keeps saturating good/CRC-error/length-error counters.
module gmii_rx_frame_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_good,
  output logic [15:0] good_cnt,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] len_err_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT     = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] crc_r;
  logic [10:0] len_r;
  logic        hold_valid_r;
  logic        hold_sof_r;
  logic [7:0]  hold_data_r;
  logic        sfd_s;
  logic        data_byte_s;
  logic        frame_end_s;
  logic        len_bad_s;
  logic        crc_bad_s;

  // Reflected CRC-32, one byte per call, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign sfd_s       = (state_r == ST_PREAMBLE) && gmii_rx_dv && (gmii_rxd == 8'hD5);
  assign data_byte_s = (state_r == ST_DATA) && gmii_rx_dv;
  assign frame_end_s = (state_r == ST_DATA) && !gmii_rx_dv;
  assign len_bad_s   = (len_r < MIN_LEN_C) || (len_r > MAX_LEN_C);
  assign crc_bad_s   = (crc_r != CRC_RESIDUE);

  // Next-state decode for preamble hunting, frame data and discard.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!gmii_rx_dv) begin
          state_s = ST_IDLE;
        end else if (gmii_rxd == 8'h55) begin
          state_s = ST_PREAMBLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_s = ST_IDLE;
        end else if (gmii_rxd == 8'h55) begin
          state_s = ST_PREAMBLE;
        end else if (gmii_rxd == 8'hD5) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!gmii_rx_dv) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DROP: begin
        if (!gmii_rx_dv) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, CRC/length accumulation, two-stage byte pipeline and statistics.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      crc_r        <= 32'h0000_0000;
      len_r        <= 11'd0;
      hold_valid_r <= 1'b0;
      hold_sof_r   <= 1'b0;
      hold_data_r  <= 8'h00;
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      frame_done   <= 1'b0;
      frame_good   <= 1'b0;
      good_cnt     <= 16'd0;
      crc_err_cnt  <= 16'd0;
      len_err_cnt  <= 16'd0;
    end else begin
      state_r <= state_s;
      if (sfd_s) begin
        len_r <= 11'd0;
        crc_r <= CRC_INIT;
      end else if (data_byte_s) begin
        len_r <= (len_r == LEN_SAT) ? len_r : len_r + 11'd1;
        crc_r <= crc32_byte(crc_r, gmii_rxd);
      end
      hold_valid_r <= data_byte_s;
      hold_sof_r   <= data_byte_s && (len_r == 11'd0);
      hold_data_r  <= data_byte_s ? gmii_rxd : 8'h00;
      // The byte in the holding register is the last one when dv drops behind it.
      out_valid    <= hold_valid_r;
      out_data     <= hold_valid_r ? hold_data_r : 8'h00;
      out_sof      <= hold_valid_r && hold_sof_r;
      out_eof      <= hold_valid_r && frame_end_s;
      frame_done   <= hold_valid_r && frame_end_s;
      frame_good   <= hold_valid_r && frame_end_s && !len_bad_s && !crc_bad_s;
      if (frame_end_s) begin
        if (len_bad_s) begin
          len_err_cnt <= sat_inc16(len_err_cnt);
        end else if (crc_bad_s) begin
          crc_err_cnt <= sat_inc16(crc_err_cnt);
        end else begin
          good_cnt <= sat_inc16(good_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Directed bench for gmii_rx_frame_check: good, corrupted, short, bad-SFD,
// zero/one-byte, mid-frame reset and back-to-back frames.
module tb_gmii_rx_frame_check;

  logic        rgmii_clk = 1'b0;
  logic        rst = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;
  logic        frame_good;
  logic [15:0] good_cnt;
  logic [15:0] crc_err_cnt;
  logic [15:0] len_err_cnt;

  gmii_rx_frame_check #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .rgmii_clk   (rgmii_clk),
    .rst         (rst),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .frame_done  (frame_done),
    .frame_good  (frame_good),
    .good_cnt    (good_cnt),
    .crc_err_cnt (crc_err_cnt),
    .len_err_cnt (len_err_cnt)
  );

  always #5 rgmii_clk = ~rgmii_clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] frame_q[$];
  logic [7:0] rx_q[$];
  int         sof_idx = -1;
  int         eof_idx = -1;
  int         done_cnt = 0;
  int         good_strobes = 0;
  int         valid_starts = 0;
  int         bad_align = 0;
  logic       prev_valid = 1'b0;
  time        sof_time = 0;
  time        first_drive_time = 0;

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge rgmii_clk) begin
    if (out_valid === 1'b1) begin
      if (prev_valid !== 1'b1) valid_starts++;
      if (out_sof === 1'b1) begin
        sof_idx  = rx_q.size();
        sof_time = $time;
      end
      if (out_eof === 1'b1) eof_idx = rx_q.size();
      rx_q.push_back(out_data);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (frame_good === 1'b1) good_strobes++;
    end
    if (frame_done !== out_eof) bad_align++;
    prev_valid = out_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    sof_idx = -1;
    eof_idx = -1;
    done_cnt = 0;
    good_strobes = 0;
    valid_starts = 0;
    bad_align = 0;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    @(negedge rgmii_clk);
  endtask

  // Standard Ethernet FCS: reflected CRC-32, init all-ones, final inversion.
  function automatic logic [31:0] eth_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[k]) begin
      c = c ^ {24'h0, q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n_payload, input int seed);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < n_payload; i++) frame_q.push_back(8'(i * 7 + seed));
    fcs = eth_crc(frame_q);
    frame_q.push_back(fcs[7:0]);
    frame_q.push_back(fcs[15:8]);
    frame_q.push_back(fcs[23:16]);
    frame_q.push_back(fcs[31:24]);
  endtask

  task automatic send_frame(input logic [7:0] sfd, input int gap);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, sfd);
    first_drive_time = $time;
    foreach (frame_q[i]) drive(1'b1, frame_q[i]);
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] ref_q[$];
    int errs;

    ref_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_model_ref", eth_crc(ref_q), 32'hCBF4_3926);

    // Reset state
    @(negedge rgmii_clk);
    rst = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_done", 32'({out_sof, out_eof, frame_done, frame_good}), 32'd0);
    check("rst_counters", {good_cnt, crc_err_cnt | len_err_cnt}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00);
    clear_mon();

    // Good 64-byte frame
    build_frame(60, 3);
    send_frame(8'hD5, 4);
    check("good_len", rx_q.size(), 32'd64);
    check("good_sof_idx", 32'(sof_idx), 32'd0);
    check("good_eof_idx", 32'(eof_idx), 32'd63);
    check("good_contig", 32'(valid_starts), 32'd1);
    check("good_latency", 32'(sof_time - first_drive_time), 32'd20);
    errs = 0;
    for (int i = 0; i < 64; i++) if (i >= rx_q.size() || rx_q[i] !== frame_q[i]) errs++;
    check("good_bytes", 32'(errs), 32'd0);
    check("good_done", 32'(done_cnt), 32'd1);
    check("good_flag", 32'(good_strobes), 32'd1);
    check("good_align", 32'(bad_align), 32'd0);
    check("good_cnt_1", 32'(good_cnt), 32'd1);
    check("good_errcnts", {crc_err_cnt, len_err_cnt}, 32'd0);

    // CRC error: payload byte 10 flipped
    clear_mon();
    build_frame(60, 3);
    frame_q[10] = frame_q[10] ^ 8'h01;
    send_frame(8'hD5, 4);
    check("crc_done", 32'(done_cnt), 32'd1);
    check("crc_flag", 32'(good_strobes), 32'd0);
    check("crc_cnts", {crc_err_cnt, good_cnt}, {16'd1, 16'd1});
    check("crc_len_cnt", 32'(len_err_cnt), 32'd0);

    // 60-byte frame with valid FCS: length error
    clear_mon();
    build_frame(56, 11);
    send_frame(8'hD5, 4);
    check("short_len", rx_q.size(), 32'd60);
    check("short_done", {16'(done_cnt), 16'(good_strobes)}, {16'd1, 16'd0});
    check("short_cnts", {len_err_cnt, crc_err_cnt}, {16'd1, 16'd1});
    check("short_good_cnt", 32'(good_cnt), 32'd1);

    // Bad SFD (0xD4): silently dropped
    clear_mon();
    build_frame(60, 3);
    send_frame(8'hD4, 4);
    check("badsfd_out", rx_q.size(), 32'd0);
    check("badsfd_done", 32'(done_cnt), 32'd0);
    check("badsfd_cnts", {good_cnt, crc_err_cnt}, {16'd1, 16'd1});
    check("badsfd_len_cnt", 32'(len_err_cnt), 32'd1);

    // Zero data bytes after SFD: counted as length error, nothing emitted
    clear_mon();
    frame_q.delete();
    send_frame(8'hD5, 4);
    check("zero_out", rx_q.size(), 32'd0);
    check("zero_done", 32'(done_cnt), 32'd0);
    check("zero_len_cnt", 32'(len_err_cnt), 32'd2);

    // One-byte frame: SOF and EOF on the same byte
    clear_mon();
    frame_q = {8'hA7};
    send_frame(8'hD5, 4);
    check("one_len", rx_q.size(), 32'd1);
    check("one_sof_eof", {16'(sof_idx), 16'(eof_idx)}, 32'd0);
    check("one_data", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'hA7);
    check("one_done", {16'(done_cnt), 16'(good_strobes)}, {16'd1, 16'd0});
    check("one_len_cnt", 32'(len_err_cnt), 32'd3);

    // Reset asserted for one cycle at byte 30 of a good frame
    clear_mon();
    build_frame(60, 3);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 64; i++) begin
      if (i == 30) rst = 1'b1;
      drive(1'b1, frame_q[i]);
      if (i == 30) begin
        rst = 1'b0;
        check("mid_rst_out", 32'({out_valid, out_sof, out_eof, frame_done, frame_good}), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        check("mid_rst_cnt_a", {good_cnt, crc_err_cnt}, 32'd0);
        check("mid_rst_cnt_b", 32'(len_err_cnt), 32'd0);
        clear_mon();
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00);
    check("mid_rst_tail_out", rx_q.size(), 32'd0);
    check("mid_rst_tail_done", 32'(done_cnt), 32'd0);
    check("mid_rst_tail_cnts", {good_cnt, len_err_cnt}, 32'd0);
    build_frame(60, 5);
    send_frame(8'hD5, 4);
    check("post_rst_good", {16'(good_strobes), good_cnt}, {16'd1, 16'd1});
    check("post_rst_errs", {crc_err_cnt, len_err_cnt}, 32'd0);

    // Two good frames, second preamble the cycle after dv falls
    clear_mon();
    build_frame(60, 3);
    send_frame(8'hD5, 1);
    build_frame(60, 99);
    send_frame(8'hD5, 4);
    check("b2b_len", rx_q.size(), 32'd128);
    check("b2b_done", 32'(done_cnt), 32'd2);
    check("b2b_flags", 32'(good_strobes), 32'd2);
    check("b2b_starts", 32'(valid_starts), 32'd2);
    check("b2b_align", 32'(bad_align), 32'd0);
    check("b2b_good_cnt", 32'(good_cnt), 32'd3);
    check("b2b_errs", {crc_err_cnt, len_err_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
